// File: rtl/ram_ctrl.sv
// ram_ctrl: MIPS byte/half/word load-store to word-RAM initiator; optional RAM_CTRL_ALIGN_TRAP_EN traps misaligned half/word accesses
module ram_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_oe,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_read_data
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP, ERR} state_t;
  state_t state_q, state_d;
  logic [1:0] size_q, off_q;
  logic sgn_q;
  logic [15:0] wdata_q;
  logic acc, bad, mis;
  logic [4:0] sh;
  logic [31:0] mask, lane, ext, merged;
  assign acc = req_valid & req_ready;
`ifdef RAM_CTRL_ALIGN_TRAP_EN
  assign mis = (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign bad = |req_addr[31:ADDR_W+2] | &req_size | mis;
  // Big-endian lane select: offset 0 is the top byte; halves only look at offset bit 1
  always_comb begin
    sh = size_q == 2'b00 ? {~off_q, 3'b000} : size_q == 2'b01 ? {~off_q[1], 4'b0000} : 5'd0;
    mask = size_q == 2'b00 ? 32'hFF << sh : size_q == 2'b01 ? 32'hFFFF << sh : '1;
    lane = (ram_read_data & mask) >> sh;
    ext = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
          size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : lane;
    merged = (ram_read_data & ~mask) | (({16'h0, wdata_q} << sh) & mask);
  end
  // Next-state: errors skip the RAM entirely, sub-word stores go through read-modify-write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = bad ? ERR : !req_we ? RD : req_size == 2'b10 ? WR : RMW_RD;
      RD, WR:  state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // Registered outputs derived from the upcoming state; reset kills any RAM cycle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      ram_cs         <= 1'b0;
      ram_rd         <= 1'b1;
      ram_oe         <= 1'b0;
      ram_addr       <= '0;
      ram_write_data <= '0;
      size_q         <= '0;
      off_q          <= '0;
      sgn_q          <= 1'b0;
      wdata_q        <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= state_d == IDLE;
      ram_cs     <= state_d inside {RD, WR, RMW_RD, RMW_WR};
      ram_rd     <= !(state_d inside {WR, RMW_WR});
      ram_oe     <= state_d inside {RD, RMW_RD};
      resp_valid <= state_d inside {RESP, ERR};
      resp_err   <= state_d == ERR;
      resp_rdata <= state_q == RD ? ext : '0;
      if (acc) begin
        size_q         <= req_size;
        off_q          <= req_addr[1:0];
        sgn_q          <= req_signed;
        wdata_q        <= req_wdata[15:0];
        ram_addr       <= req_addr[ADDR_W+1:2];
        ram_write_data <= req_wdata;
      end
      if (state_q == RMW_RD) ram_write_data <= merged;
    end
  end
endmodule
